uart_rx_buf: RTL and testbench

- Downstream stage of the UART receiver. Consumes the receiver's byte strobe, data byte and parity-error flag.
- The parity flag settles later than the strobe, so each byte is held in a staging register for a fixed error-capture window.
- After the window, {err, data} is pushed into a synchronous FIFO.
- The host drains the FIFO through a valid/ready interface; overflow and occupancy status are exported.

---
 rtl/uart_rx_buf_pkg.sv | 28 ++
 rtl/uart_rx_buf_if.sv | 30 +++
 rtl/uart_rx_buf_sync_fifo.sv | 87 ++++++++
 rtl/uart_rx_buf.sv | 131 +++++++++++++
 tb/tb_uart_rx_buf.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_buf_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the UART receive buffer slice.
//   UART_DATA_W   : default received data width
//   rx_entry_t    : one FIFO entry, {err, data}
//   stg_state_e   : staging FSM states
//   err_wait_calc : error-capture window length from clock and baud rate
// ----------------------------------------------------------------------------
package uart_pkg;

   localparam int UART_DATA_W = 32'sd8;

   typedef struct packed {
      logic                   err;
      logic [UART_DATA_W-1:0] data;
   } rx_entry_t;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } stg_state_e;

   // One bit time of clocks plus two cycles of margin for the late parity flag.
   function automatic int err_wait_calc(input int clk_freq, input int baud_rate);
      return (clk_freq / baud_rate) + 32'sd2;
   endfunction

endpackage

// File: rtl/uart_rx_buf_if.sv
// ----------------------------------------------------------------------------
// uart_rx_buf_if
// Byte path of the receive buffer: the receiver-side strobe bundle and the
// host-side valid/ready drain port.
//   rx_data/rx_vld/rx_err : from UART receiver
//   dout/dout_err/dout_vld: FIFO head towards host
//   dout_rdy              : host accept
// slave  = buffer side, master = receiver/host side.
// ----------------------------------------------------------------------------
interface uart_rx_buf_if #(
   parameter int DATA_W = 32'sd8
);
   logic [DATA_W-1:0] rx_data;
   logic              rx_vld;
   logic              rx_err;
   logic [DATA_W-1:0] dout;
   logic              dout_err;
   logic              dout_vld;
   logic              dout_rdy;

   modport slave (
      input  rx_data, rx_vld, rx_err, dout_rdy,
      output dout, dout_err, dout_vld
   );

   modport master (
      output rx_data, rx_vld, rx_err, dout_rdy,
      input  dout, dout_err, dout_vld
   );
endinterface

// File: rtl/uart_rx_buf_sync_fifo.sv
// ----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with binary pointers and a separate occupancy counter.
// A push into a full FIFO is dropped unless a pop happens in the same cycle.
//   CLK, rst_n : clock, asynchronous active-low reset
//   push_i     : write request, wdata_i : write data
//   pop_i      : read request (ignored when empty)
//   rdata_o    : head entry (combinational)
//   count_o    : occupancy 0..DEPTH
//   full_o     : count_o == DEPTH, empty_o : count_o == 0
//   drop_o     : a push was discarded this cycle
// ----------------------------------------------------------------------------
module sync_fifo #(
   parameter int WIDTH = 32'sd9,
   parameter int DEPTH = 32'sd16
) (
   input  logic                     CLK,
   input  logic                     rst_n,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic                     drop_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 32'sd1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic [CW-1:0]    count_d;
   logic             do_push;
   logic             do_pop;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == {CW{1'b0}});
   assign count_o = count_q;
   assign rdata_o = mem_q[rd_ptr_q];

   // Accept/drop decision; a pop frees the slot a full-FIFO push needs.
   always_comb begin
      do_pop  = pop_i & ~empty_o;
      do_push = push_i & (~full_o | do_pop);
      drop_o  = push_i & full_o & ~do_pop;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CW'(1'b1);
         2'b01:   count_d = count_q - CW'(1'b1);
         default: count_d = count_q;
      endcase
   end

   // Storage array; cleared on reset so the head reads zero when empty.
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= {WIDTH{1'b0}};
         end
      end else if (do_push) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end else begin
         mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= {AW{1'b0}};
         rd_ptr_q <= {AW{1'b0}};
         count_q  <= {CW{1'b0}};
      end else begin
         if (do_push) begin
            wr_ptr_q <= wr_ptr_q + AW'(1'b1);
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1'b1);
         end
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/uart_rx_buf.sv
// ----------------------------------------------------------------------------
// uart_rx_buf
// Holds each received byte for an error-capture window so the late parity
// flag can be merged in, then commits {err, data} into a FIFO drained by the
// host over valid/ready.
//   CLK, rst_n : clock, asynchronous active-low reset
//   bus        : receiver strobe in / host drain port (slave modport)
//   count      : FIFO occupancy 0..DEPTH
//   full       : FIFO full
//   overflow   : sticky, set when a commit is dropped
//   ovf_clr    : synchronous clear of overflow (a same-cycle drop wins)
// ----------------------------------------------------------------------------
module uart_rx_buf
   import uart_pkg::*;
#(
   parameter int DATA_W   = UART_DATA_W,
   parameter int DEPTH    = 32'sd16,
   parameter int ERR_WAIT = err_wait_calc(32'sd10_000_000, 32'sd115_200)
) (
   input  logic                   CLK,
   input  logic                   rst_n,
   uart_rx_buf_if.slave           bus,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   overflow,
   input  logic                   ovf_clr
);

   localparam int CNT_W = (ERR_WAIT > 32'sd1) ? $clog2(ERR_WAIT) : 32'sd1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ERR_WAIT - 32'sd1);

   stg_state_e        state_q;
   logic [DATA_W-1:0] stg_data_q;
   logic              stg_err_q;
   logic [CNT_W-1:0]  wait_cnt_q;
   logic              overflow_q;

   logic              commit;
   logic [DATA_W:0]   commit_word;
   logic [DATA_W:0]   head;
   logic              fifo_empty;
   logic              drop;

   // Commit at the end of the window, or early when a new strobe displaces
   // the staged byte; rx_err of the commit cycle itself still counts.
   always_comb begin
      commit      = 1'b0;
      commit_word = {stg_err_q | bus.rx_err, stg_data_q};
      case (state_q)
         IDLE:    commit = 1'b0;
         HOLD:    commit = (wait_cnt_q == LAST_CNT) | bus.rx_vld;
         default: commit = 1'b0;
      endcase
   end

   // Staging FSM: capture a byte, accumulate its error flag over the window.
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         stg_data_q <= {DATA_W{1'b0}};
         stg_err_q  <= 1'b0;
         wait_cnt_q <= {CNT_W{1'b0}};
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.rx_vld) begin
                  stg_data_q <= bus.rx_data;
                  stg_err_q  <= bus.rx_err;
                  wait_cnt_q <= {CNT_W{1'b0}};
                  state_q    <= HOLD;
               end else begin
                  state_q    <= IDLE;
               end
            end
            HOLD: begin
               if (bus.rx_vld) begin
                  // Previous byte commits this cycle; restart the window.
                  stg_data_q <= bus.rx_data;
                  stg_err_q  <= bus.rx_err;
                  wait_cnt_q <= {CNT_W{1'b0}};
                  state_q    <= HOLD;
               end else if (wait_cnt_q == LAST_CNT) begin
                  state_q    <= IDLE;
               end else begin
                  stg_err_q  <= stg_err_q | bus.rx_err;
                  wait_cnt_q <= wait_cnt_q + CNT_W'(1'b1);
                  state_q    <= HOLD;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   // Sticky overflow; a drop in the clear cycle keeps the flag set.
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         overflow_q <= 1'b0;
      end else if (drop) begin
         overflow_q <= 1'b1;
      end else if (ovf_clr) begin
         overflow_q <= 1'b0;
      end else begin
         overflow_q <= overflow_q;
      end
   end

   sync_fifo #(
      .WIDTH (DATA_W + 32'sd1),
      .DEPTH (DEPTH)
   ) u_fifo (
      .CLK     (CLK),
      .rst_n   (rst_n),
      .push_i  (commit),
      .wdata_i (commit_word),
      .pop_i   (bus.dout_rdy),
      .rdata_o (head),
      .count_o (count),
      .full_o  (full),
      .empty_o (fifo_empty),
      .drop_o  (drop)
   );

   assign bus.dout     = head[DATA_W-1:0];
   assign bus.dout_err = head[DATA_W];
   assign bus.dout_vld = ~fifo_empty;
   assign overflow     = overflow_q;

endmodule

// File: tb/tb_uart_rx_buf.sv
// ----------------------------------------------------------------------------
// tb_uart_rx_buf
// Self-checking bench: directed table, hand sequences, randomized traffic,
// all compared against a time-based behavioural model (deadline per staged
// byte, queue for the FIFO).
// ----------------------------------------------------------------------------
module tb_uart_rx_buf;
   import uart_pkg::*;

   localparam int DW    = 8;
   localparam int DEPTH = 16;
   localparam int EW    = 88;

   logic       CLK = 1'b0;
   logic       rst_n = 1'b0;
   logic       ovf_clr = 1'b0;
   logic [4:0] count;
   logic       full;
   logic       overflow;

   uart_rx_buf_if #(.DATA_W(DW)) bus ();

   uart_rx_buf #(.DATA_W(DW), .DEPTH(DEPTH), .ERR_WAIT(EW)) dut (
      .CLK      (CLK),
      .rst_n    (rst_n),
      .bus      (bus.slave),
      .count    (count),
      .full     (full),
      .overflow (overflow),
      .ovf_clr  (ovf_clr)
   );

   always #5 CLK = ~CLK;

   int nvec = 0;
   int nerr = 0;

   // ---------------- reference model ----------------
   rx_entry_t  mq[$];
   bit         m_ovf;
   bit         stg_v;
   logic [7:0] stg_d;
   bit         stg_e;
   int         stg_deadline;
   int         cyc = 0;

   function automatic void model_reset();
      mq.delete();
      m_ovf = 1'b0;
      stg_v = 1'b0;
      stg_e = 1'b0;
   endfunction

   // One clock edge: the staged byte commits on its deadline cycle or when
   // displaced by a new strobe; the FIFO pops before a push is judged.
   function automatic void model_cycle();
      rx_entry_t w;
      bit pop;
      bit commit;
      bit drop;
      drop   = 1'b0;
      pop    = (mq.size() != 0) && bus.dout_rdy;
      commit = stg_v && ((cyc == stg_deadline) || bus.rx_vld);
      w.err  = stg_e | bus.rx_err;
      w.data = stg_d;
      if (pop) void'(mq.pop_front());
      if (commit) begin
         if (mq.size() < DEPTH) mq.push_back(w);
         else drop = 1'b1;
      end
      if (ovf_clr) m_ovf = 1'b0;
      if (drop) m_ovf = 1'b1;
      if (bus.rx_vld) begin
         stg_v = 1'b1;
         stg_d = bus.rx_data;
         stg_e = bus.rx_err;
         stg_deadline = cyc + EW;
      end else if (commit) begin
         stg_v = 1'b0;
      end else if (stg_v) begin
         stg_e = stg_e | bus.rx_err;
      end
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic check_outputs();
      chk("dout_vld", 32'(bus.dout_vld), 32'(mq.size() != 0));
      chk("count", 32'(count), 32'(mq.size()));
      chk("full", 32'(full), 32'(mq.size() == DEPTH));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      if (mq.size() != 0) begin
         chk("dout", 32'(bus.dout), 32'(mq[0].data));
         chk("dout_err", 32'(bus.dout_err), 32'(mq[0].err));
      end
   endtask

   task automatic step();
      @(posedge CLK);
      if (!rst_n) model_reset();
      else model_cycle();
      cyc++;
      #1;
      check_outputs();
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   task automatic send(input logic [7:0] d, input logic e);
      bus.rx_data = d;
      bus.rx_vld  = 1'b1;
      bus.rx_err  = e;
      step();
      bus.rx_vld  = 1'b0;
      bus.rx_err  = 1'b0;
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      logic [7:0] data;
      int         err_off;   // cycle offset of rx_err pulse from strobe, -1 none
      logic       exp_err;
   } vec_t;

   vec_t tbl[6];
   logic [7:0] exp_seq[$];

   initial begin
      int lat;
      bit got;

      tbl[0] = '{8'hA5, -1, 1'b0};
      tbl[1] = '{8'h3C, 40, 1'b1};
      tbl[2] = '{8'h3C, 89, 1'b0};   // one cycle after the commit edge
      tbl[3] = '{8'h96,  0, 1'b1};   // error in the strobe cycle
      tbl[4] = '{8'h5A, 88, 1'b1};   // error in the commit cycle
      tbl[5] = '{8'hC3, 87, 1'b1};

      bus.rx_data  = 8'h00;
      bus.rx_vld   = 1'b0;
      bus.rx_err   = 1'b0;
      bus.dout_rdy = 1'b0;
      model_reset();

      // reset state
      idle(2);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_vld", 32'(bus.dout_vld), 32'd0);
      chk("rst_dout", 32'({bus.dout_err, bus.dout}), 32'd0);
      chk("rst_ovf", 32'(overflow), 32'd0);
      rst_n = 1'b1;
      idle(2);

      // table: latency, late-error window edges, single pop
      for (int t = 0; t < 6; t++) begin
         got = 1'b0;
         lat = 0;
         for (int k = 0; k < EW + 5; k++) begin
            bus.rx_data = tbl[t].data;
            bus.rx_vld  = (k == 0);
            bus.rx_err  = (k == tbl[t].err_off);
            step();
            if (!got && bus.dout_vld) begin
               got = 1'b1;
               lat = k + 1;
            end
         end
         bus.rx_vld = 1'b0;
         bus.rx_err = 1'b0;
         chk("tbl_latency", 32'(lat), 32'(EW + 1));
         chk("tbl_dout", 32'(bus.dout), 32'(tbl[t].data));
         chk("tbl_err", 32'(bus.dout_err), 32'(tbl[t].exp_err));
         chk("tbl_count", 32'(count), 32'd1);
         bus.dout_rdy = 1'b1;
         step();
         bus.dout_rdy = 1'b0;
         chk("tbl_pop_count", 32'(count), 32'd0);
      end

      // back-to-back strobe at wait_cnt == 10
      send(8'hAA, 1'b0);
      idle(10);
      send(8'h55, 1'b0);
      chk("b2b_first_count", 32'(count), 32'd1);
      chk("b2b_first_data", 32'(bus.dout), 32'hAA);
      idle(EW - 1);
      chk("b2b_not_yet", 32'(count), 32'd1);
      step();
      chk("b2b_second_count", 32'(count), 32'd2);
      bus.dout_rdy = 1'b1;
      step();
      chk("b2b_second_data", 32'(bus.dout), 32'h55);
      chk("b2b_second_err", 32'(bus.dout_err), 32'd0);
      step();
      bus.dout_rdy = 1'b0;

      // full with simultaneous push and pop on the commit cycle
      for (int i = 0; i < DEPTH; i++) begin
         send(8'(8'h80 + i), 1'b0);
         idle(2);
      end
      send(8'h77, 1'b0);           // commits 0x8F, stages 0x77
      chk("fp_full", 32'(full), 32'd1);
      idle(EW - 1);
      bus.dout_rdy = 1'b1;
      step();                       // commit cycle of 0x77
      bus.dout_rdy = 1'b0;
      chk("fp_count", 32'(count), 32'd16);
      chk("fp_ovf", 32'(overflow), 32'd0);
      chk("fp_head", 32'(bus.dout), 32'h81);
      exp_seq.delete();
      for (int i = 1; i < DEPTH; i++) exp_seq.push_back(8'(8'h80 + i));
      exp_seq.push_back(8'h77);
      bus.dout_rdy = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         chk("fp_drain", 32'(bus.dout), 32'(exp_seq[i]));
         step();
      end
      bus.dout_rdy = 1'b0;
      chk("fp_empty", 32'(bus.dout_vld), 32'd0);

      // overflow: 17 bytes into 16 entries
      for (int i = 0; i < 17; i++) begin
         send(8'(i), 1'b0);
         idle(2);
      end
      idle(EW + 2);
      chk("ovf_full", 32'(full), 32'd1);
      chk("ovf_count", 32'(count), 32'd16);
      chk("ovf_flag", 32'(overflow), 32'd1);
      bus.dout_rdy = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         chk("ovf_drain", 32'(bus.dout), 32'(i));
         step();
      end
      bus.dout_rdy = 1'b0;
      chk("ovf_drained", 32'(count), 32'd0);
      chk("ovf_sticky", 32'(overflow), 32'd1);
      ovf_clr = 1'b1;
      step();
      ovf_clr = 1'b0;
      chk("ovf_clr", 32'(overflow), 32'd0);

      // reset mid-window with 3 queued entries
      for (int i = 0; i < 4; i++) begin
         send(8'(8'hE0 + i), 1'b0);
         idle(2);
      end
      idle(20);
      chk("rstm_pre_count", 32'(count), 32'd3);
      rst_n = 1'b0;
      #1;
      chk("rstm_count", 32'(count), 32'd0);
      chk("rstm_vld", 32'(bus.dout_vld), 32'd0);
      chk("rstm_ovf", 32'(overflow), 32'd0);
      idle(2);
      rst_n = 1'b1;
      idle(EW + 10);
      chk("rstm_no_commit", 32'(count), 32'd0);
      chk("rstm_no_vld", 32'(bus.dout_vld), 32'd0);

      // randomized traffic, alternating slow and fast drain phases
      for (int c = 0; c < 4000; c++) begin
         bus.rx_vld   = ($urandom_range(0, 29) == 0);
         bus.rx_data  = 8'($urandom);
         bus.rx_err   = ($urandom_range(0, 39) == 0);
         if (((c / 500) % 2) == 0) bus.dout_rdy = ($urandom_range(0, 49) == 0);
         else bus.dout_rdy = ($urandom_range(0, 1) == 0);
         ovf_clr      = ($urandom_range(0, 99) == 0);
         step();
      end
      bus.rx_vld   = 1'b0;
      bus.rx_err   = 1'b0;
      bus.dout_rdy = 1'b0;
      ovf_clr      = 1'b0;
      idle(4);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
